prim_ram_2p_arb: RTL and testbench

Round-robin arbiter that shares one port of the dual-port SRAM primitive among NumReq requesters (e.g. USB core, CPU data bus, debug) on a single clock. It forwards the granted requester's command to the RAM port in the same cycle. It routes the one-cycle-late RAM read data back to the requester that issued it. The other RAM port stays dedicated to its own master.

---
 rtl/prim_ram_2p_arb.sv | 66 ++++++
 tb/tb_prim_ram_2p_arb.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/prim_ram_2p_arb.sv
// prim_ram_2p_arb: round-robin / fixed-priority arbiter sharing one SRAM port among NumReq requesters.
module prim_ram_2p_arb #(
  parameter int NumReq          = 3,
  parameter int Width           = 32,
  parameter int Depth           = 1024,
  parameter int DataBitsPerMask = 8,
  parameter int RoundRobin      = 1,
  localparam int AW = $clog2(Depth),
  localparam int MW = Width / DataBitsPerMask
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumReq-1:0]    req_i,
  output logic [NumReq-1:0]    gnt_o,
  input  logic [NumReq-1:0]    write_i,
  input  logic [NumReq*AW-1:0] addr_i,
  input  logic [NumReq*Width-1:0] wdata_i,
  input  logic [NumReq*MW-1:0] wmask_i,
  output logic [NumReq-1:0]    rvalid_o,
  output logic [Width-1:0]     rdata_o,
  output logic                 mem_req_o,
  output logic                 mem_write_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [Width-1:0]     mem_wdata_o,
  output logic [MW-1:0]        mem_wmask_o,
  input  logic [Width-1:0]     mem_rdata_i
);
  localparam int IW = $clog2(NumReq);
  logic [IW-1:0] ptr_q, ptr_d, win, id_q;
  logic found, any, rv_q, we_q;
  // ptr_q stays 0 in fixed-priority mode, so the same search serves both modes
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      if (!found && req_i[(int'(ptr_q) + k) % NumReq]) begin
        found = 1'b1;
        win = IW'((int'(ptr_q) + k) % NumReq);
      end
    end
  end
  assign any         = |req_i && !rst_i;
  assign gnt_o       = any ? NumReq'(1) << win : '0;
  assign mem_req_o   = any;
  assign mem_write_o = any && write_i[win];
  assign mem_addr_o  = any ? addr_i[win*AW +: AW] : '0;
  assign mem_wdata_o = any ? wdata_i[win*Width +: Width] : '0;
  assign mem_wmask_o = any ? wmask_i[win*MW +: MW] : '0;
  assign ptr_d = (any && RoundRobin != 0) ? (win == IW'(NumReq - 1) ? '0 : win + 1'b1) : ptr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      rv_q  <= 1'b0;
      id_q  <= '0;
      we_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      rv_q  <= any;
      id_q  <= win;
      we_q  <= mem_write_o;
    end
  end
  // a response pending while reset is raised is dropped, not delivered
  assign rvalid_o = (rv_q && !rst_i) ? NumReq'(1) << id_q : '0;
  assign rdata_o  = (rv_q && !we_q && !rst_i) ? mem_rdata_i : '0;
endmodule

// File: tb/tb_prim_ram_2p_arb.sv
// tb_prim_ram_2p_arb: reference-model and directed checks for round-robin and fixed-priority instances.
module tb_prim_ram_2p_arb;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0]  req = '0, wr = '0;
  logic [29:0] addr = '0;
  logic [95:0] wdata = '0;
  logic [11:0] wmask = '0;
  logic [2:0]  gnt [2], rvalid [2];
  logic [31:0] rdata [2], mwd [2], mrd [2];
  logic        mreq [2], mwr [2];
  logic [9:0]  maddr [2];
  logic [3:0]  mmask [2];
  logic [31:0] ram [2][1024];
  logic [31:0] gold [2][1024];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  prim_ram_2p_arb #(.RoundRobin(1)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[0]), .write_i(wr), .addr_i(addr),
    .wdata_i(wdata), .wmask_i(wmask), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
    .mem_req_o(mreq[0]), .mem_write_o(mwr[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwd[0]),
    .mem_wmask_o(mmask[0]), .mem_rdata_i(mrd[0]));

  prim_ram_2p_arb #(.RoundRobin(0)) dut_fp (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[1]), .write_i(wr), .addr_i(addr),
    .wdata_i(wdata), .wmask_i(wmask), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
    .mem_req_o(mreq[1]), .mem_write_o(mwr[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwd[1]),
    .mem_wmask_o(mmask[1]), .mem_rdata_i(mrd[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM port model: one-cycle read latency, output held otherwise
  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 1024; i++) ram[d][i] = 32'h5A5A0000 ^ 32'(i);
      ram[d][16] = 32'hDEADBEEF;
      ram[d][4]  = 32'hAABBCCDD;
      mrd[d] = 32'h0BAD0BAD;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++)
        if (mreq[d]) begin
          if (mwr[d]) begin
            for (int b = 0; b < 4; b++)
              if (mmask[d][b]) ram[d][maddr[d]][b*8 +: 8] <= mwd[d][b*8 +: 8];
          end else mrd[d] <= ram[d][maddr[d]];
        end
    end
  end

  // reference model: evaluated mid-cycle, then advanced to the next cycle
  initial begin
    int ptr [2];
    bit rv [2], we [2];
    int id [2];
    logic [31:0] dat [2];
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 1024; i++) gold[d][i] = 32'h5A5A0000 ^ 32'(i);
      gold[d][16] = 32'hDEADBEEF;
      gold[d][4]  = 32'hAABBCCDD;
      ptr[d] = 0; rv[d] = 0; we[d] = 0; id[d] = 0; dat[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        int w;
        bit act;
        logic [9:0] a;
        logic [31:0] wd, m;
        w = -1;
        for (int k = 0; k < 3; k++)
          if (w < 0 && req[(ptr[d] + k) % 3]) w = (ptr[d] + k) % 3;
        act = !rst && w >= 0;
        a  = act ? addr[w*10 +: 10] : '0;
        wd = act ? wdata[w*32 +: 32] : '0;
        m  = act ? 32'(wmask[w*4 +: 4]) : '0;
        chk($sformatf("d%0d gnt", d), 32'(gnt[d]), act ? 32'(1) << w : 0);
        chk($sformatf("d%0d mem_req", d), 32'(mreq[d]), 32'(act));
        chk($sformatf("d%0d mem_write", d), 32'(mwr[d]), act ? 32'(wr[w]) : 0);
        chk($sformatf("d%0d mem_addr", d), 32'(maddr[d]), 32'(a));
        chk($sformatf("d%0d mem_wdata", d), mwd[d], wd);
        chk($sformatf("d%0d mem_wmask", d), 32'(mmask[d]), m);
        chk($sformatf("d%0d rvalid", d), 32'(rvalid[d]), (!rst && rv[d]) ? 32'(1) << id[d] : 0);
        chk($sformatf("d%0d rdata", d), rdata[d], (!rst && rv[d] && !we[d]) ? dat[d] : 0);
        if (rst) begin
          ptr[d] = 0; rv[d] = 0;
        end else if (act) begin
          rv[d] = 1; id[d] = w; we[d] = wr[w]; dat[d] = gold[d][a];
          if (wr[w]) for (int b = 0; b < 4; b++) if (m[b]) gold[d][a][b*8 +: 8] = wd[b*8 +: 8];
          ptr[d] = d == 0 ? (w + 1) % 3 : 0;
        end else rv[d] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input int i, input bit w, input logic [9:0] a, input logic [31:0] dv, input logic [3:0] m);
    wr[i] = w;
    addr[i*10 +: 10] = a;
    wdata[i*32 +: 32] = dv;
    wmask[i*4 +: 4] = m;
  endtask

  initial begin
    repeat (2) tick();
    req = 3'b111;
    #1 chk("rst gnt", 32'(gnt[0]), 0);
    chk("rst mem_req", 32'(mreq[0]), 0);
    tick(); rst = 0; req = '0;
    #1 chk("post-rst rvalid", 32'(rvalid[0]), 0);
    chk("post-rst rdata", rdata[0], 0);
    tick(); set(0, 0, 10'h010, '0, '0); req = 3'b001;
    #1 chk("read gnt", 32'(gnt[0]), 32'b001);
    chk("read addr", 32'(maddr[0]), 32'h010);
    tick(); req = '0;
    #1 chk("read rvalid", 32'(rvalid[0]), 32'b001);
    chk("read rdata", rdata[0], 32'hDEADBEEF);
    tick(); set(1, 1, 10'h004, 32'h11223344, 4'b0101); req = 3'b010;
    tick(); set(1, 0, 10'h004, '0, '0);
    #1 chk("write rvalid", 32'(rvalid[0]), 32'b010);
    chk("write rdata", rdata[0], 0);
    tick(); req = '0;
    #1 chk("rmw rvalid", 32'(rvalid[0]), 32'b010);
    chk("rmw rdata", rdata[0], 32'hAA22CC44);
    tick(); rst = 1;
    tick(); rst = 0;
    for (int i = 0; i < 3; i++) set(i, 0, 10'h020 + 10'(i), '0, '0);
    req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1 chk($sformatf("rr gnt %0d", c), 32'(gnt[0]), 32'b001 << (c % 3));
      chk($sformatf("fp gnt %0d", c), 32'(gnt[1]), 32'b001);
      chk($sformatf("rr mem_req %0d", c), 32'(mreq[0]), 1);
      tick();
    end
    req = 3'b110;
    #1 chk("fp drop0 gnt", 32'(gnt[1]), 32'b010);
    chk("rr drop0 gnt", 32'(gnt[0]), 32'b010);
    tick(); req = 3'b011;
    #1 chk("wrap gnt", 32'(gnt[0]), 32'b001);
    tick();
    #1 chk("wrap ptr1 gnt", 32'(gnt[0]), 32'b010);
    tick(); set(2, 0, 10'h030, '0, '0); req = 3'b100;
    #1 chk("pre-rst gnt", 32'(gnt[0]), 32'b100);
    tick(); rst = 1; req = 3'b110;
    #1 chk("mid-rst rvalid", 32'(rvalid[0]), 0);
    chk("mid-rst rdata", rdata[0], 0);
    chk("mid-rst gnt", 32'(gnt[0]), 0);
    tick(); rst = 0;
    #1 chk("after-rst rvalid", 32'(rvalid[0]), 0);
    chk("after-rst rdata", rdata[0], 0);
    chk("after-rst gnt", 32'(gnt[0]), 32'b010);
    tick(); req = '0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
